sd_serial_add_ctrl: RTL and testbench

//  Sequencer for the shared 6-bit three-operand signed-digit adder slice.

---
 rtl/sd_pkg.sv | 18 +
 rtl/sd_serial_add_ctrl_if.sv | 54 +++++
 rtl/sd_slice_mux.sv | 58 +++++
 rtl/sd_serial_add_ctrl.sv | 120 ++++++++++++
 tb/tb_sd_serial_add_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared parameters and types for the serial signed-digit adder sequencer
package sd_pkg;

    localparam int BITS   = 6;
    localparam int SLICES = 4;
    localparam int W      = BITS * SLICES;
    localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef logic [1:0]       sd_carry_t;
    typedef logic [CNT_W-1:0] sd_cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sd_ctrl_state_t;

endpackage

// File: rtl/sd_serial_add_ctrl_if.sv
// rtl/sd_serial_add_ctrl_if.sv - request, adder-slice and result buses of the sequencer
interface sd_serial_add_ctrl_if;
    import sd_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    x_plus;
    logic [W-1:0]    x_minus;
    logic [W-1:0]    y_plus;
    logic [W-1:0]    y_minus;
    logic [W-1:0]    r_plus;
    logic [W-1:0]    r_minus;

    logic [BITS-1:0] a_x_plus;
    logic [BITS-1:0] a_x_minus;
    logic [BITS-1:0] a_y_plus;
    logic [BITS-1:0] a_y_minus;
    logic [BITS-1:0] a_r_plus;
    logic [BITS-1:0] a_r_minus;
    sd_carry_t       a_cin_one;
    sd_carry_t       a_cin_two;
    logic [BITS-1:0] a_sum_plus;
    logic [BITS-1:0] a_sum_minus;
    sd_carry_t       a_cout_one;
    sd_carry_t       a_cout_two;

    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    sum_plus;
    logic [W-1:0]    sum_minus;
    sd_carry_t       cout_one;
    sd_carry_t       cout_two;

    modport slave (
        input  in_valid, x_plus, x_minus, y_plus, y_minus, r_plus, r_minus,
        output in_ready,
        output a_x_plus, a_x_minus, a_y_plus, a_y_minus, a_r_plus, a_r_minus,
        output a_cin_one, a_cin_two,
        input  a_sum_plus, a_sum_minus, a_cout_one, a_cout_two,
        output out_valid, sum_plus, sum_minus, cout_one, cout_two,
        input  out_ready
    );

    modport master (
        output in_valid, x_plus, x_minus, y_plus, y_minus, r_plus, r_minus,
        input  in_ready,
        input  a_x_plus, a_x_minus, a_y_plus, a_y_minus, a_r_plus, a_r_minus,
        input  a_cin_one, a_cin_two,
        output a_sum_plus, a_sum_minus, a_cout_one, a_cout_two,
        input  out_valid, sum_plus, sum_minus, cout_one, cout_two,
        output out_ready
    );

endinterface

// File: rtl/sd_slice_mux.sv
// rtl/sd_slice_mux.sv - operand holding registers and per-cycle slice selection
module sd_slice_mux
    import sd_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_en,
    input  sd_cnt_t         i_sel,
    input  logic [W-1:0]    i_x_plus,
    input  logic [W-1:0]    i_x_minus,
    input  logic [W-1:0]    i_y_plus,
    input  logic [W-1:0]    i_y_minus,
    input  logic [W-1:0]    i_r_plus,
    input  logic [W-1:0]    i_r_minus,
    output logic [BITS-1:0] o_x_plus,
    output logic [BITS-1:0] o_x_minus,
    output logic [BITS-1:0] o_y_plus,
    output logic [BITS-1:0] o_y_minus,
    output logic [BITS-1:0] o_r_plus,
    output logic [BITS-1:0] o_r_minus
);

    logic [W-1:0]    w_op_in [6];
    logic [W-1:0]    r_op    [6];
    logic [BITS-1:0] w_slice [6];

    assign w_op_in[0] = i_x_plus;
    assign w_op_in[1] = i_x_minus;
    assign w_op_in[2] = i_y_plus;
    assign w_op_in[3] = i_y_minus;
    assign w_op_in[4] = i_r_plus;
    assign w_op_in[5] = i_r_minus;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) r_op[i] <= '0;
        end else if (i_load) begin
            for (int i = 0; i < 6; i++) r_op[i] <= w_op_in[i];
        end
    end

    // Buses idle at zero outside RUN so the shared adder sees no stale digits.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_slice[i] = '0;
            if (i_en) w_slice[i] = r_op[i][i_sel*BITS +: BITS];
        end
    end

    assign o_x_plus  = w_slice[0];
    assign o_x_minus = w_slice[1];
    assign o_y_plus  = w_slice[2];
    assign o_y_minus = w_slice[3];
    assign o_r_plus  = w_slice[4];
    assign o_r_minus = w_slice[5];

endmodule

// File: rtl/sd_serial_add_ctrl.sv
// rtl/sd_serial_add_ctrl.sv - feeds one wide three-operand signed-digit add through a BITS-wide adder slice
module sd_serial_add_ctrl
    import sd_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    sd_serial_add_ctrl_if.slave  bus
);

    localparam sd_cnt_t LAST = sd_cnt_t'(SLICES - 1);

    sd_ctrl_state_t r_state;
    sd_ctrl_state_t w_next_state;
    sd_cnt_t        r_cnt;
    sd_carry_t      r_cin_one;
    sd_carry_t      r_cin_two;
    sd_carry_t      r_cout_one;
    sd_carry_t      r_cout_two;
    logic [W-1:0]   r_sum_plus;
    logic [W-1:0]   r_sum_minus;
    logic           w_accept;
    logic           w_run;
    logic           w_last;
    logic           w_in_ready;
    logic           w_out_valid;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_run        = 1'b0;
        w_accept     = 1'b0;
        w_last       = (r_cnt == LAST);
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (w_last) w_next_state = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Carries travel unmodified between slices, including 2'b11.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_cin_one   <= '0;
            r_cin_two   <= '0;
            r_cout_one  <= '0;
            r_cout_two  <= '0;
            r_sum_plus  <= '0;
            r_sum_minus <= '0;
        end else begin
            if (w_accept) begin
                r_cnt     <= '0;
                r_cin_one <= '0;
                r_cin_two <= '0;
            end
            if (w_run) begin
                r_sum_plus[r_cnt*BITS +: BITS]  <= bus.a_sum_plus;
                r_sum_minus[r_cnt*BITS +: BITS] <= bus.a_sum_minus;
                r_cin_one <= bus.a_cout_one;
                r_cin_two <= bus.a_cout_two;
                if (w_last) begin
                    r_cnt      <= '0;
                    r_cout_one <= bus.a_cout_one;
                    r_cout_two <= bus.a_cout_two;
                end else begin
                    r_cnt <= r_cnt + sd_cnt_t'(1);
                end
            end
        end
    end

    sd_slice_mux u_slice_mux (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_accept),
        .i_en      (w_run),
        .i_sel     (r_cnt),
        .i_x_plus  (bus.x_plus),
        .i_x_minus (bus.x_minus),
        .i_y_plus  (bus.y_plus),
        .i_y_minus (bus.y_minus),
        .i_r_plus  (bus.r_plus),
        .i_r_minus (bus.r_minus),
        .o_x_plus  (bus.a_x_plus),
        .o_x_minus (bus.a_x_minus),
        .o_y_plus  (bus.a_y_plus),
        .o_y_minus (bus.a_y_minus),
        .o_r_plus  (bus.a_r_plus),
        .o_r_minus (bus.a_r_minus)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.a_cin_one = w_run ? r_cin_one : 2'b00;
    assign bus.a_cin_two = w_run ? r_cin_two : 2'b00;
    assign bus.sum_plus  = r_sum_plus;
    assign bus.sum_minus = r_sum_minus;
    assign bus.cout_one  = r_cout_one;
    assign bus.cout_two  = r_cout_two;

endmodule

// File: tb/tb_sd_serial_add_ctrl.sv
// tb/tb_sd_serial_add_ctrl.sv - directed and random checks of the serial adder sequencer
module tb_sd_serial_add_ctrl;
    import sd_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic force_c1 = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sd_serial_add_ctrl_if bus ();

    sd_serial_add_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural slice adder: plus and minus digits each summed with their own carry pair.
    logic [BITS+1:0] t_p, t_m;
    always_comb begin
        t_p = (BITS+2)'(bus.a_x_plus) + (BITS+2)'(bus.a_y_plus)
            + (BITS+2)'(bus.a_r_plus) + (BITS+2)'(bus.a_cin_one);
        t_m = (BITS+2)'(bus.a_x_minus) + (BITS+2)'(bus.a_y_minus)
            + (BITS+2)'(bus.a_r_minus) + (BITS+2)'(bus.a_cin_two);
        bus.a_sum_plus  = t_p[BITS-1:0];
        bus.a_sum_minus = t_m[BITS-1:0];
        bus.a_cout_one  = force_c1 ? 2'b01 : t_p[BITS+1:BITS];
        bus.a_cout_two  = t_m[BITS+1:BITS];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [W-1:0] xp, xm, yp, ym, rp, rm);
        bus.x_plus  = xp;
        bus.x_minus = xm;
        bus.y_plus  = yp;
        bus.y_minus = ym;
        bus.r_plus  = rp;
        bus.r_minus = rm;
    endtask

    task automatic ref_add(input logic [W-1:0] a, b, c, output logic [W-1:0] s, output logic [1:0] co);
        logic [W+1:0] t;
        t  = {2'b00, a} + {2'b00, b} + {2'b00, c};
        s  = t[W-1:0];
        co = t[W+1:W];
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic start_op();
        int k = 0;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) check_eq("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Counts posedges after the accept edge until out_valid is seen; ends at a negedge.
    task automatic wait_done(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.out_valid || cyc >= 20) break;
            @(posedge clk);
            cyc++;
        end
        if (!bus.out_valid) check_eq("done_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] sp, sm, input logic [1:0] c1, c2);
        check_eq({tag, "_sum_plus"},  32'(bus.sum_plus),  32'(sp));
        check_eq({tag, "_sum_minus"}, 32'(bus.sum_minus), 32'(sm));
        check_eq({tag, "_cout_one"},  32'(bus.cout_one),  32'(c1));
        check_eq({tag, "_cout_two"},  32'(bus.cout_two),  32'(c2));
    endtask

    logic [W-1:0] vec    [3][6];
    logic [W-1:0] exp_sp [3];
    logic [W-1:0] exp_sm [3];
    logic [1:0]   exp_c1 [3];
    logic [1:0]   exp_c2 [3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int acc_cyc [3];
        int n_acc, n_res;
        logic [W-1:0] rs_p, rs_m, rv [6];
        logic [1:0]   rc1, rc2;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_ops('0, '0, '0, '0, '0, '0);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_a_cin_one", 32'(bus.a_cin_one), 32'd0);
        check_eq("rst_a_cin_two", 32'(bus.a_cin_two), 32'd0);
        check_eq("rst_a_x_plus", 32'(bus.a_x_plus), 32'd0);
        check_result("rst", '0, '0, 2'b00, 2'b00);

        // Single LSB digit, latency
        set_ops(24'h000001, '0, '0, '0, '0, '0);
        start_op();
        wait_done(cyc);
        check_eq("lsb_latency", 32'(cyc), 32'd4);
        check_eq("lsb_in_ready_done", 32'(bus.in_ready), 32'd0);
        check_result("lsb", 24'h000001, 24'h000000, 2'b00, 2'b00);
        finish_op();
        check_eq("lsb_out_valid_after", 32'(bus.out_valid), 32'd0);
        check_eq("lsb_in_ready_after", 32'(bus.in_ready), 32'd1);

        // Forced carry out of slice 0 must appear as carry in on slice 1
        set_ops('0, '0, '0, '0, '0, '0);
        start_op();
        force_c1 = 1'b1;
        @(posedge clk);
        #1 force_c1 = 1'b0;
        @(negedge clk);
        check_eq("force_cin_one_s1", 32'(bus.a_cin_one), 32'd1);
        check_eq("force_cin_two_s1", 32'(bus.a_cin_two), 32'd0);
        wait_done(cyc);
        check_result("force", 24'h000040, 24'h000000, 2'b00, 2'b00);
        finish_op();
        set_ops(24'h00003F, '0, 24'h00003F, '0, 24'h00003F, '0);
        start_op();
        @(negedge clk);
        check_eq("next_cin_one_s0", 32'(bus.a_cin_one), 32'd0);
        wait_done(cyc);
        check_result("slice0_carry", 24'h0000BD, 24'h000000, 2'b00, 2'b00);
        finish_op();

        // Stall in DONE with a competing request
        set_ops(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000001);
        start_op();
        wait_done(cyc);
        set_ops(24'h123456, 24'h654321, 24'h111111, 24'h222222, 24'h333333, 24'h444444);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check_eq("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check_result("stall", 24'hFFFFFD, 24'hFFFFFF, 2'b10, 2'b01);
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        finish_op();
        check_eq("stall_out_valid_after", 32'(bus.out_valid), 32'd0);

        // Reset during RUN slice 2
        set_ops(24'h03F03F, 24'h000FFF, 24'h03F03F, 24'h000FFF, 24'h03F03F, 24'h000FFF);
        start_op();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_a_cin_one", 32'(bus.a_cin_one), 32'd0);
        check_eq("midrst_a_cin_two", 32'(bus.a_cin_two), 32'd0);
        check_eq("midrst_sum_plus", 32'(bus.sum_plus), 32'd0);
        check_eq("midrst_sum_minus", 32'(bus.sum_minus), 32'd0);
        reset = 1'b0;

        // Back-to-back operations with in_valid and out_ready held high
        vec[0] = '{24'h000010, 24'h000000, 24'h000020, 24'h000000, 24'h000003, 24'h000000};
        vec[1] = '{24'h000000, 24'h00F000, 24'h000000, 24'h001000, 24'h000000, 24'h000001};
        vec[2] = '{24'hFFFFFF, 24'h000005, 24'h000001, 24'h000005, 24'h000000, 24'h000005};
        exp_sp = '{24'h000033, 24'h000000, 24'h000000};
        exp_sm = '{24'h000000, 24'h010001, 24'h00000F};
        exp_c1 = '{2'b00, 2'b00, 2'b01};
        exp_c2 = '{2'b00, 2'b00, 2'b00};
        n_acc = 0;
        n_res = 0;
        set_ops(vec[0][0], vec[0][1], vec[0][2], vec[0][3], vec[0][4], vec[0][5]);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 60 && n_res < 3; c++) begin
            logic accepting;
            accepting = 1'b0;
            if (bus.out_valid) begin
                check_result("b2b", exp_sp[n_res], exp_sm[n_res], exp_c1[n_res], exp_c2[n_res]);
                n_res++;
            end
            if (bus.in_ready && bus.in_valid && n_acc < 3) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                accepting = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepting) begin
                if (n_acc < 3)
                    set_ops(vec[n_acc][0], vec[n_acc][1], vec[n_acc][2],
                            vec[n_acc][3], vec[n_acc][4], vec[n_acc][5]);
                else
                    bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_eq("b2b_results", 32'(n_res), 32'd3);
        check_eq("b2b_accepts", 32'(n_acc), 32'd3);
        if (n_acc == 3) begin
            check_eq("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
            check_eq("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
        end
        @(negedge clk);

        // Random operands against the wide reference
        for (int n = 0; n < 1000; n++) begin
            for (int j = 0; j < 6; j++) rv[j] = W'($urandom);
            if (n % 8 == 0) rv[0] = '1;
            if (n % 8 == 0) rv[2] = '1;
            ref_add(rv[0], rv[2], rv[4], rs_p, rc1);
            ref_add(rv[1], rv[3], rv[5], rs_m, rc2);
            set_ops(rv[0], rv[1], rv[2], rv[3], rv[4], rv[5]);
            start_op();
            wait_done(cyc);
            check_result("rand", rs_p, rs_m, rc1, rc2);
            finish_op();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
